cache_op_controller: RTL
========================

# cache_op_controller

Sequencing front-end for the cache memory block: accepts one GET/PUT/DEL request at a time over a valid/ready handshake and drives the memory block's key, value, index and control lines. It interprets the block's registered hit/index/value results and allocates a free entry for new keys. It returns a status/value response over a second valid/ready handshake. It sits between the host command decoder and the memory block, and is the only master of the memory block's control inputs.

## Interface

**Parameters**
- NUM_ENTRIES, 16: number of cache entries; this is also the width of the one-hot index and used-entry vectors.
- KEY_WIDTH, 16: key width.
- VALUE_WIDTH, 64: value width.
- CNT_WIDTH, $clog2(NUM_ENTRIES+1): width of the occupancy counter.

**Ports**
- clk, in, 1: clock.
- rst_n, in, 1: reset; asynchronous, active-low.
- Request channel:
  - req_valid, in, 1: request present.
  - req_ready, out, 1: controller can accept a request.
  - req_op, in, 2: operation code; 0=GET, 1=PUT, 2=DEL, 3=reserved.
  - req_key, in, KEY_WIDTH: request key.
  - req_value, in, VALUE_WIDTH: value to store (PUT only).
- Response channel:
  - resp_valid, out, 1: response present.
  - resp_ready, in, 1: consumer takes the response.
  - resp_status, out, 2: 0=OK, 1=NOT_FOUND, 2=FULL, 3=INVALID.
  - resp_value, out, VALUE_WIDTH: read value on a GET hit; 0 otherwise.
  - resp_index, out, NUM_ENTRIES: one-hot entry that was read, written or deleted; 0 if none.
- Memory block control outputs:
  - mem_write, out, 1: write strobe.
  - mem_delete, out, 1: delete strobe.
  - mem_select_by_index, out, 1: index-select mode; tied 0.
  - mem_key, mem_value, mem_index, out, KEY_WIDTH / VALUE_WIDTH / NUM_ENTRIES: memory block data lines.
- Memory block result inputs:
  - mem_value_out, mem_index_out, mem_hit, in: registered lookup results (1-cycle latency).
  - mem_used_entries, in, NUM_ENTRIES: per-entry occupancy flags.
- Status outputs:
  - busy, out, 1: controller is not in IDLE.
  - entry_count, out, CNT_WIDTH: registered popcount of mem_used_entries.

## Operation

**States:** IDLE, LOOKUP, EVAL, WRITE, RESP.

**IDLE**
- req_ready=1.
- On req_valid, capture op, key and value.
- If key==0 or op==3: go to RESP with status INVALID.
- Otherwise: go to LOOKUP.

**LOOKUP**
- Drive mem_key=captured key, with no strobes.
- Next state is EVAL unconditionally.

**EVAL**
- mem_key is still driven; the memory results now reflect the lookup.
- GET: on hit, latch mem_value_out and mem_index_out, status OK; on miss, status NOT_FOUND. Go to RESP.
- PUT, hit: target = mem_index_out (in-place update). Go to WRITE.
- PUT, miss, some mem_used_entries bit == 0: target = lowest-numbered free entry as a one-hot value. Go to WRITE.
- PUT, miss, all entries used: status FULL, resp_index=0. Go to RESP.
- DEL, hit: target = mem_index_out. Go to WRITE.
- DEL, miss: status NOT_FOUND. Go to RESP.

**WRITE**
- For exactly one cycle, assert mem_write (PUT) or mem_delete (DEL).
- Drive mem_index=target, mem_key=key, mem_value=value (0 for DEL).
- Set status OK and resp_index=target.
- Go to RESP.

**RESP**
- resp_valid=1.
- Hold resp_status, resp_value and resp_index stable until resp_ready.
- On resp_ready, go to IDLE.

**Defaults and invariants**
- Outside LOOKUP, EVAL and WRITE: mem_key=0, mem_value=0, mem_index=0, all strobes 0.
- mem_write and mem_delete are never both high.
- At most one mem_index bit is set at any time.
- Exactly one request is in flight; a new request is not accepted in the RESP cycle in which resp_ready is sampled.
- entry_count is updated every cycle from mem_used_entries.

## Timing

**Reset**
- All outputs reset to 0, except req_ready, which is 1.
- State resets to IDLE and any in-flight request is dropped with no response.
- The memory block shares rst_n, so its contents clear at the same time.

**Latency**, counted in rising edges after the accepting edge (req_valid && req_ready):
- INVALID: resp_valid high after edge 0.
- GET, PUT-FULL and DEL-miss: resp_valid high after edge 2.
- PUT and DEL-hit: mem strobe high during the cycle after edge 2; resp_valid high after edge 3.

**Stalls and ordering**
- resp_ready held low stalls indefinitely in RESP, with outputs unchanged.
- The earliest next accept is the edge after the one where resp_ready is sampled high.
- A write's mem_used_entries effect is visible from the cycle after WRITE. It therefore influences entry_count one edge later and the next request's EVAL.

## Test plan

- **Reset, then fill:** PUT key 0x0001 value 0xA5 → OK, resp_index=0x0001, entry_count=1. Then GET 0x0001 → OK, value 0xA5, resp_valid high 2 edges after accept.
- **Update in place:** PUT 0x0001 value 0xB6 → OK, resp_index=0x0001, entry_count unchanged. Then GET → 0xB6.
- **Full:** PUT 16 distinct keys 0x0001..0x0010 → resp_index 0x0001..0x8000 in order. A 17th PUT of 0x0011 → FULL, resp_index=0, no mem_write pulse.
- **Delete and reuse:** DEL key 0x0005 → OK, resp_index=0x0010. GET 0x0005 → NOT_FOUND. PUT 0x0020 → resp_index=0x0010.
- **Invalid and stall:** request with key 0 or op 3 → INVALID with no mem activity. With resp_ready held low for 5 cycles, response fields stay stable and req_ready stays 0.
- **Reset mid-operation:** assert rst_n low during WRITE of a PUT → no response emitted, state IDLE, entry_count=0, and a subsequent GET of that key → NOT_FOUND.

Source files
------------

// File: rtl/cache_op_controller.sv
// Request sequencer for the cache memory block: GET/PUT/DEL over valid/ready,
// drives the block's control lines and returns status/value responses.
module cache_op_controller #(
  parameter int NUM_ENTRIES = 16,
  parameter int KEY_WIDTH   = 16,
  parameter int VALUE_WIDTH = 64,
  parameter int CNT_WIDTH   = $clog2(NUM_ENTRIES + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [1:0]             req_op,
  input  logic [KEY_WIDTH-1:0]   req_key,
  input  logic [VALUE_WIDTH-1:0] req_value,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [1:0]             resp_status,
  output logic [VALUE_WIDTH-1:0] resp_value,
  output logic [NUM_ENTRIES-1:0] resp_index,
  output logic                   mem_write,
  output logic                   mem_delete,
  output logic                   mem_select_by_index,
  output logic [KEY_WIDTH-1:0]   mem_key,
  output logic [VALUE_WIDTH-1:0] mem_value,
  output logic [NUM_ENTRIES-1:0] mem_index,
  input  logic [VALUE_WIDTH-1:0] mem_value_out,
  input  logic [NUM_ENTRIES-1:0] mem_index_out,
  input  logic                   mem_hit,
  input  logic [NUM_ENTRIES-1:0] mem_used_entries,
  output logic                   busy,
  output logic [CNT_WIDTH-1:0]   entry_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_EVAL,
    S_WRITE,
    S_RESP
  } state_t;

  localparam logic [1:0] OP_GET = 2'd0;
  localparam logic [1:0] OP_PUT = 2'd1;
  localparam logic [1:0] OP_DEL = 2'd2;
  localparam logic [1:0] OP_RSV = 2'd3;

  localparam logic [1:0] ST_OK   = 2'd0;
  localparam logic [1:0] ST_NF   = 2'd1;
  localparam logic [1:0] ST_FULL = 2'd2;
  localparam logic [1:0] ST_INV  = 2'd3;

  localparam logic [NUM_ENTRIES-1:0] ONE = NUM_ENTRIES'(1);

  state_t state_q, state_d;

  logic [1:0]             op_q, op_d;
  logic [KEY_WIDTH-1:0]   key_q, key_d;
  logic [VALUE_WIDTH-1:0] val_q, val_d;
  logic [NUM_ENTRIES-1:0] tgt_q, tgt_d;

  logic                   req_ready_q, req_ready_d;
  logic                   resp_valid_q, resp_valid_d;
  logic [1:0]             resp_status_q, resp_status_d;
  logic [VALUE_WIDTH-1:0] resp_value_q, resp_value_d;
  logic [NUM_ENTRIES-1:0] resp_index_q, resp_index_d;
  logic                   mem_write_q, mem_write_d;
  logic                   mem_delete_q, mem_delete_d;
  logic [KEY_WIDTH-1:0]   mem_key_q, mem_key_d;
  logic [VALUE_WIDTH-1:0] mem_value_q, mem_value_d;
  logic [NUM_ENTRIES-1:0] mem_index_q, mem_index_d;
  logic                   busy_q, busy_d;
  logic [CNT_WIDTH-1:0]   entry_count_q, entry_count_d;

  logic [NUM_ENTRIES-1:0] free_v;
  logic [NUM_ENTRIES-1:0] first_free;
  logic                   all_used;
  logic                   is_get, is_put, is_del;
  logic                   mem_active;

  // two's-complement trick isolates the lowest free entry as one-hot
  assign free_v     = ~mem_used_entries;
  assign first_free = free_v & (~free_v + ONE);
  assign all_used   = &mem_used_entries;

  assign is_get = (op_q == OP_GET);
  assign is_put = (op_q == OP_PUT);
  assign is_del = (op_q == OP_DEL);

  always_comb begin
    entry_count_d = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      entry_count_d = entry_count_d
        + CNT_WIDTH'(mem_used_entries[i]);
    end
  end

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    key_d         = key_q;
    val_d         = val_q;
    tgt_d         = tgt_q;
    resp_status_d = resp_status_q;
    resp_value_d  = resp_value_q;
    resp_index_d  = resp_index_q;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d  = req_op;
          key_d = req_key;
          val_d = req_value;
          if (req_key == '0 || req_op == OP_RSV) begin
            state_d       = S_RESP;
            resp_status_d = ST_INV;
            resp_value_d  = '0;
            resp_index_d  = '0;
          end else begin
            state_d = S_LOOKUP;
          end
        end
      end
      S_LOOKUP: state_d = S_EVAL;
      S_EVAL: begin
        unique case (1'b1)
          is_get: begin
            state_d = S_RESP;
            if (mem_hit) begin
              resp_status_d = ST_OK;
              resp_value_d  = mem_value_out;
              resp_index_d  = mem_index_out;
            end else begin
              resp_status_d = ST_NF;
              resp_value_d  = '0;
              resp_index_d  = '0;
            end
          end
          is_put: begin
            if (mem_hit) begin
              tgt_d   = mem_index_out;
              state_d = S_WRITE;
            end else if (!all_used) begin
              tgt_d   = first_free;
              state_d = S_WRITE;
            end else begin
              state_d       = S_RESP;
              resp_status_d = ST_FULL;
              resp_value_d  = '0;
              resp_index_d  = '0;
            end
          end
          is_del: begin
            if (mem_hit) begin
              tgt_d   = mem_index_out;
              state_d = S_WRITE;
            end else begin
              state_d       = S_RESP;
              resp_status_d = ST_NF;
              resp_value_d  = '0;
              resp_index_d  = '0;
            end
          end
          default: begin
            state_d       = S_RESP;
            resp_status_d = ST_INV;
            resp_value_d  = '0;
            resp_index_d  = '0;
          end
        endcase
      end
      S_WRITE: begin
        state_d       = S_RESP;
        resp_status_d = ST_OK;
        resp_value_d  = '0;
        resp_index_d  = tgt_q;
      end
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // outputs are registered, so decode them from the next state
    mem_active   = (state_d == S_LOOKUP)
                || (state_d == S_EVAL)
                || (state_d == S_WRITE);
    req_ready_d  = (state_d == S_IDLE);
    resp_valid_d = (state_d == S_RESP);
    busy_d       = (state_d != S_IDLE);
    mem_key_d    = mem_active ? key_d : '0;
    mem_write_d  = (state_d == S_WRITE) && (op_d == OP_PUT);
    mem_delete_d = (state_d == S_WRITE) && (op_d == OP_DEL);
    mem_value_d  = mem_write_d ? val_d : '0;
    mem_index_d  = (state_d == S_WRITE) ? tgt_d : '0;

    if (state_d == S_IDLE) begin
      resp_status_d = '0;
      resp_value_d  = '0;
      resp_index_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      op_q          <= '0;
      key_q         <= '0;
      val_q         <= '0;
      tgt_q         <= '0;
      req_ready_q   <= 1'b1;
      resp_valid_q  <= 1'b0;
      resp_status_q <= '0;
      resp_value_q  <= '0;
      resp_index_q  <= '0;
      mem_write_q   <= 1'b0;
      mem_delete_q  <= 1'b0;
      mem_key_q     <= '0;
      mem_value_q   <= '0;
      mem_index_q   <= '0;
      busy_q        <= 1'b0;
      entry_count_q <= '0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      key_q         <= key_d;
      val_q         <= val_d;
      tgt_q         <= tgt_d;
      req_ready_q   <= req_ready_d;
      resp_valid_q  <= resp_valid_d;
      resp_status_q <= resp_status_d;
      resp_value_q  <= resp_value_d;
      resp_index_q  <= resp_index_d;
      mem_write_q   <= mem_write_d;
      mem_delete_q  <= mem_delete_d;
      mem_key_q     <= mem_key_d;
      mem_value_q   <= mem_value_d;
      mem_index_q   <= mem_index_d;
      busy_q        <= busy_d;
      entry_count_q <= entry_count_d;
    end
  end

  assign req_ready           = req_ready_q;
  assign resp_valid          = resp_valid_q;
  assign resp_status         = resp_status_q;
  assign resp_value          = resp_value_q;
  assign resp_index          = resp_index_q;
  assign mem_write           = mem_write_q;
  assign mem_delete          = mem_delete_q;
  assign mem_select_by_index = 1'b0;
  assign mem_key             = mem_key_q;
  assign mem_value           = mem_value_q;
  assign mem_index           = mem_index_q;
  assign busy                = busy_q;
  assign entry_count         = entry_count_q;

endmodule
